// File: rtl/i2s_audio_tx_pkg.sv
// Shared frame constants, types and slot-decoding helpers for the I2S transmitter.
package i2s_audio_tx_pkg;

    localparam int FRAME_BITS     = 32;
    localparam int SAMPLE_W       = 16;
    localparam int LEFT_MSB_SLOT  = 0;
    localparam int RIGHT_MSB_SLOT = 16;
    localparam int LR_HIGH_FIRST  = 15;
    localparam int LR_HIGH_LAST   = 30;

    localparam int SLOT_W     = $clog2(FRAME_BITS);
    localparam int SAMPLE_IW  = $clog2(SAMPLE_W);

    typedef logic [SLOT_W-1:0] slot_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } frame_t;

    // Word select is raised one slot ahead of the right-channel MSB and dropped one slot ahead of the left MSB.
    function automatic logic lrclk_of(slot_t k);
        return (int'(k) >= LR_HIGH_FIRST) && (int'(k) <= LR_HIGH_LAST);
    endfunction

    function automatic logic sdin_of(frame_t f, slot_t k);
        int kk;
        kk = int'(k);
        if (kk < RIGHT_MSB_SLOT)
            return f.left[SAMPLE_IW'(SAMPLE_W - 1 - (kk - LEFT_MSB_SLOT))];
        return f.right[SAMPLE_IW'(SAMPLE_W - 1 - (kk - RIGHT_MSB_SLOT))];
    endfunction

endpackage

// File: rtl/i2s_audio_tx_if.sv
// CPU/memory-side sample write and status bus of the I2S transmitter.
interface i2s_audio_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      wr_data;
    logic             wr_en;
    logic             flags_clr;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_low_int;
    logic             underrun;
    logic             overflow;

    modport master (
        output wr_data, wr_en, flags_clr,
        input  fifo_level, fifo_full, fifo_low_int, underrun, overflow
    );

    modport slave (
        input  wr_data, wr_en, flags_clr,
        output fifo_level, fifo_full, fifo_low_int, underrun, overflow
    );
endinterface

// File: rtl/i2s_audio_tx_fifo.sv
// Synchronous sample FIFO with occupancy count; pushes when full and pops when empty are ignored.
module audio_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (level == LVL_W'(DEPTH));
        empty   = (level == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/i2s_audio_tx.sv
// Stereo Philips-I2S transmitter: MCLK/SCLK dividers, 32-slot bit counter, frame shift register and status flags.
module i2s_audio_tx
    import i2s_audio_tx_pkg::*;
#(
    parameter int MCLK_DIV   = 4,
    parameter int SCLK_DIV   = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_THRESH = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          enable,
    i2s_audio_tx_if.slave bus,
    output logic          I2S_MCLK,
    output logic          I2S_SCLK,
    output logic          I2S_LRCLK,
    output logic          I2S_SDIN
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int MC_W  = $clog2(MCLK_DIV);
    localparam int SC_W  = $clog2(SCLK_DIV);

    logic [MC_W-1:0]  mclk_cnt, mclk_nxt;
    logic [SC_W-1:0]  sclk_cnt, sclk_nxt;
    slot_t            bit_cnt, bit_nxt;
    frame_t           shreg, frame_nxt;
    logic             sclk_fall, frame_start;
    logic             push_ok, pop;
    logic [31:0]      fifo_head;
    logic [LVL_W-1:0] level;
    logic             fifo_full, fifo_empty;
    logic             underrun_q, overflow_q, low_int_q;

    audio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (bus.wr_en),
        .pop    (pop),
        .din    (bus.wr_data),
        .dout   (fifo_head),
        .level  (level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        mclk_nxt    = (mclk_cnt == MC_W'(MCLK_DIV - 1)) ? '0 : mclk_cnt + 1'b1;
        sclk_nxt    = (sclk_cnt == SC_W'(SCLK_DIV - 1)) ? '0 : sclk_cnt + 1'b1;
        bit_nxt     = bit_cnt + slot_t'(1);
        sclk_fall   = enable && (sclk_cnt == SC_W'(SCLK_DIV - 1));
        frame_start = sclk_fall && (bit_nxt == '0);
        pop         = frame_start && !fifo_empty;
        push_ok     = bus.wr_en && !fifo_full;
        frame_nxt   = fifo_empty ? '0 : frame_t'(fifo_head);
    end

    // Pin registers are driven from the next counter values so SCLK falls on the same edge that moves LRCLK/SDIN.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mclk_cnt  <= '0;
            sclk_cnt  <= '0;
            bit_cnt   <= '1;
            shreg     <= '0;
            I2S_MCLK  <= 1'b0;
            I2S_SCLK  <= 1'b0;
            I2S_LRCLK <= 1'b0;
            I2S_SDIN  <= 1'b0;
        end else if (!enable) begin
            mclk_cnt  <= '0;
            sclk_cnt  <= '0;
            bit_cnt   <= '1;
            shreg     <= '0;
            I2S_MCLK  <= 1'b0;
            I2S_SCLK  <= 1'b0;
            I2S_LRCLK <= 1'b0;
            I2S_SDIN  <= 1'b0;
        end else begin
            mclk_cnt <= mclk_nxt;
            sclk_cnt <= sclk_nxt;
            I2S_MCLK <= (mclk_nxt >= MC_W'(MCLK_DIV / 2));
            I2S_SCLK <= (sclk_nxt >= SC_W'(SCLK_DIV / 2));
            if (sclk_fall) begin
                bit_cnt   <= bit_nxt;
                I2S_LRCLK <= lrclk_of(bit_nxt);
                if (frame_start) begin
                    shreg    <= frame_nxt;
                    I2S_SDIN <= sdin_of(frame_nxt, bit_nxt);
                end else begin
                    I2S_SDIN <= sdin_of(shreg, bit_nxt);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            low_int_q  <= 1'b0;
        end else begin
            low_int_q <= pop && !push_ok && (level == LVL_W'(LOW_THRESH + 1));
            if (bus.flags_clr) begin
                underrun_q <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                if (frame_start && fifo_empty)
                    underrun_q <= 1'b1;
                if (bus.wr_en && fifo_full)
                    overflow_q <= 1'b1;
            end
        end
    end

    assign bus.fifo_level   = level;
    assign bus.fifo_full    = fifo_full;
    assign bus.fifo_low_int = low_int_q;
    assign bus.underrun     = underrun_q;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: time-based behavioural model plus literal frame/period/flag checks.
module tb_i2s_audio_tx;
    localparam int DEPTH      = 16;
    localparam int LOW_THRESH = 4;

    logic clk = 1'b0;
    logic nreset;
    logic enable;
    logic I2S_MCLK, I2S_SCLK, I2S_LRCLK, I2S_SDIN;

    i2s_audio_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    i2s_audio_tx #(
        .MCLK_DIV   (4),
        .SCLK_DIV   (32),
        .FIFO_DEPTH (DEPTH),
        .LOW_THRESH (LOW_THRESH)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .enable    (enable),
        .bus       (bus),
        .I2S_MCLK  (I2S_MCLK),
        .I2S_SCLK  (I2S_SCLK),
        .I2S_LRCLK (I2S_LRCLK),
        .I2S_SDIN  (I2S_SDIN)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t = consecutive enabled edges; a slot boundary every 32 of them, a new word when the slot wraps to 0.
    int unsigned m_t    = 0;
    int          m_k    = 31;
    logic [31:0] m_word = '0;
    logic [31:0] m_q [$];
    logic        m_under = 1'b0, m_over = 1'b0, m_low = 1'b0;
    int          m_lvl0;
    bit          m_popped, m_pushed;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_q.delete();
            m_t = 0; m_k = 31; m_word = '0;
            m_under = 1'b0; m_over = 1'b0; m_low = 1'b0;
        end else begin
            m_lvl0 = m_q.size();
            m_popped = 1'b0;
            m_pushed = 1'b0;
            if (enable) begin
                m_t++;
                if (m_t % 32 == 0) begin
                    m_k = (m_k + 1) % 32;
                    if (m_k == 0) begin
                        if (m_lvl0 > 0) begin
                            m_word = m_q.pop_front();
                            m_popped = 1'b1;
                        end else begin
                            m_word = '0;
                            m_under = 1'b1;
                        end
                    end
                end
            end else begin
                m_t = 0; m_k = 31; m_word = '0;
            end
            if (bus.wr_en) begin
                if (m_lvl0 == DEPTH) m_over = 1'b1;
                else begin
                    m_q.push_back(bus.wr_data);
                    m_pushed = 1'b1;
                end
            end
            m_low = m_popped && !m_pushed && (m_lvl0 == LOW_THRESH + 1);
            if (bus.flags_clr) begin
                m_under = 1'b0;
                m_over  = 1'b0;
            end
        end
    end

    logic [4:0] m_bitidx;
    always @(posedge clk) begin
        #2;
        m_bitidx = 5'(31 - m_k);
        chk("mclk",     I2S_MCLK,  32'((m_t % 4) >= 2));
        chk("sclk",     I2S_SCLK,  32'((m_t % 32) >= 16));
        chk("lrclk",    I2S_LRCLK, 32'(m_k >= 15 && m_k <= 30));
        chk("sdin",     I2S_SDIN,  32'(m_word[m_bitidx]));
        chk("level",    32'(bus.fifo_level), 32'(m_q.size()));
        chk("full",     bus.fifo_full, 32'(m_q.size() == DEPTH));
        chk("low_int",  bus.fifo_low_int, 32'(m_low));
        chk("underrun", bus.underrun, 32'(m_under));
        chk("overflow", bus.overflow, 32'(m_over));
    end

    // Edge-to-edge period monitors and low-level interrupt counter.
    int cyc = 0, s_r = -1, m_r = -1, l_f = -1;
    int sclk_per = 0, mclk_per = 0, lr_per = 0;
    int low_pulses = 0, low_level = -1;
    logic p_sclk = 1'b0, p_mclk = 1'b0, p_lr = 1'b0;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (!enable) begin
            s_r = -1; m_r = -1; l_f = -1;
        end else begin
            if (I2S_SCLK && !p_sclk) begin if (s_r >= 0) sclk_per = cyc - s_r; s_r = cyc; end
            if (I2S_MCLK && !p_mclk) begin if (m_r >= 0) mclk_per = cyc - m_r; m_r = cyc; end
            if (!I2S_LRCLK && p_lr)  begin if (l_f >= 0) lr_per = cyc - l_f;   l_f = cyc; end
        end
        if (bus.fifo_low_int) begin
            low_pulses++;
            low_level = int'(bus.fifo_level);
        end
        p_sclk = I2S_SCLK; p_mclk = I2S_MCLK; p_lr = I2S_LRCLK;
    end

    function automatic logic [7:0] all_outs();
        return {I2S_MCLK, I2S_SCLK, I2S_LRCLK, I2S_SDIN,
                bus.fifo_full, bus.fifo_low_int, bus.underrun, bus.overflow};
    endfunction

    task automatic reset_pulse();
        @(negedge clk); nreset = 1'b0; enable = 1'b0;
        @(negedge clk); nreset = 1'b1;
    endtask

    task automatic clear_flags();
        @(negedge clk); bus.flags_clr = 1'b1;
        @(negedge clk); bus.flags_clr = 1'b0;
    endtask

    logic [31:0] cap_sd, cap_lr;

    initial begin
        nreset = 1'b0; enable = 1'b0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.flags_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs",  32'(all_outs()), 32'h0);
        chk("reset_level", 32'(bus.fifo_level), 32'h0);
        nreset = 1'b1;

        // Single known word serialised MSB first with Philips word-select timing.
        @(negedge clk); bus.wr_data = 32'hA5A5_3C3C; bus.wr_en = 1'b1;
        @(negedge clk); bus.wr_en = 1'b0; enable = 1'b1;
        cap_sd = '0; cap_lr = '0;
        repeat (48) @(posedge clk);
        #2;
        cap_sd = {cap_sd[30:0], I2S_SDIN}; cap_lr = {cap_lr[30:0], I2S_LRCLK};
        chk("first_pop_level", 32'(bus.fifo_level), 32'h0);
        for (int s = 1; s < 32; s++) begin
            repeat (32) @(posedge clk);
            #2;
            cap_sd = {cap_sd[30:0], I2S_SDIN}; cap_lr = {cap_lr[30:0], I2S_LRCLK};
        end
        chk("frame_sdin",  cap_sd, 32'hA5A5_3C3C);
        chk("frame_lrclk", cap_lr, 32'h0001_FFFE);
        repeat (1100) @(posedge clk);
        #2;
        chk("sclk_period",  32'(sclk_per), 32'd32);
        chk("mclk_period",  32'(mclk_per), 32'd4);
        chk("frame_period", 32'(lr_per),   32'd1024);
        chk("underrun_after_empty", 32'(bus.underrun), 32'h1);
        @(negedge clk); enable = 1'b0;
        clear_flags();
        chk("underrun_cleared", 32'(bus.underrun), 32'h0);

        // Empty FIFO at enable: underrun appears exactly at the first frame load.
        reset_pulse();
        enable = 1'b1;
        repeat (31) @(posedge clk);
        #2;
        chk("underrun_pre_load", 32'(bus.underrun), 32'h0);
        @(posedge clk);
        #2;
        chk("underrun_at_load", 32'(bus.underrun), 32'h1);
        chk("sdin_empty", 32'(I2S_SDIN), 32'h0);
        clear_flags();
        chk("underrun_clr", 32'(bus.underrun), 32'h0);
        enable = 1'b0;

        // Overfill while idle, then drain: one low-level interrupt at level 4.
        reset_pulse();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = $urandom;
        end
        @(negedge clk); bus.wr_en = 1'b0;
        chk("fill_level",    32'(bus.fifo_level), 32'd16);
        chk("fill_full",     32'(bus.fifo_full),  32'h1);
        chk("fill_overflow", 32'(bus.overflow),   32'h1);
        clear_flags();
        low_pulses = 0; low_level = -1;
        enable = 1'b1;
        repeat (16500) @(posedge clk);
        #2;
        chk("low_int_count", 32'(low_pulses), 32'd1);
        chk("low_int_level", 32'(low_level),  32'd4);
        chk("drain_level",   32'(bus.fifo_level), 32'h0);
        chk("drain_underrun", 32'(bus.underrun), 32'h1);
        @(negedge clk); enable = 1'b0;

        // Enable dropped at slot 20: the in-flight word is lost, next frame takes the next word.
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = $urandom;
        end
        @(negedge clk); bus.wr_en = 1'b0; enable = 1'b1;
        repeat (680) @(posedge clk);
        @(negedge clk); enable = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("drop_pins",  32'(all_outs() >> 4), 32'h0);
        chk("drop_level", 32'(bus.fifo_level), 32'd2);
        @(negedge clk); enable = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        chk("reenable_level", 32'(bus.fifo_level), 32'd1);
        repeat (1100) @(posedge clk);
        #2;
        chk("reenable_drain", 32'(bus.fifo_level), 32'd0);
        chk("reenable_no_underrun", 32'(bus.underrun), 32'h0);
        @(negedge clk); enable = 1'b0;

        // Random writes, flag clears and enable drops against the model.
        enable = 1'b1;
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            bus.wr_en     = ($urandom_range(0, 499) == 0);
            bus.wr_data   = $urandom;
            bus.flags_clr = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 2999) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
        end
        @(negedge clk); bus.wr_en = 1'b0; bus.flags_clr = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = $urandom;
        end
        @(negedge clk); bus.wr_en = 1'b0;

        // Asynchronous reset mid-run clears everything without waiting for a clock edge.
        repeat (530) @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("async_rst_outs",  32'(all_outs()), 32'h0);
        chk("async_rst_level", 32'(bus.fifo_level), 32'h0);
        repeat (2) @(negedge clk);
        enable = 1'b0; nreset = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        chk("idle_after_rst", 32'(all_outs()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
